stream_upsize_pipe: RTL and testbench

Registered, backpressure-aware stream width upsizer that packs `T_DATA_RATIO` narrow input beats into one wide output word, with correct partial-word `keep` on `last`. It sits between a narrow producer and a wide consumer on the streaming datapath. It is the next generation of the team's upsizer. It adds full ready/valid flow control on both sides, a stable held output under stall, zeroed unused lanes, and support for `T_DATA_RATIO = 1`.

---
 rtl/stream_upsize_pipe.sv | 91 +++++++++
 tb/tb_stream_upsize_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsize_pipe.sv
// Registered stream width upsizer: packs T_DATA_RATIO narrow beats
// into one wide word with full ready/valid flow control on both sides.
module stream_upsize_pipe #(
   parameter int T_DATA_WIDTH = 4,
   parameter int T_DATA_RATIO = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [T_DATA_WIDTH-1:0] s_data_i,
   input  logic                    s_last_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO],
   output logic [T_DATA_RATIO-1:0] m_keep_o,
   output logic                    m_last_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i
);

   localparam int IW = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(T_DATA_RATIO - 1);

   logic [T_DATA_WIDTH-1:0] acc [T_DATA_RATIO];
   logic [T_DATA_WIDTH-1:0] nxt_data [T_DATA_RATIO];
   logic [T_DATA_RATIO-1:0] nxt_keep;
   logic [IW-1:0]           idx;
   logic                    wr;
   logic                    rd;
   logic                    close;

   assign s_ready_o = rst_n & (~m_valid_o | m_ready_i);
   assign wr        = s_valid_i & s_ready_o;
   assign rd        = m_valid_o & m_ready_i;
   assign close     = wr & (s_last_i | (idx == IDX_TOP));

   // Lanes above idx are masked here, so acc never needs clearing.
   always_comb begin
      for (int j = 0; j < T_DATA_RATIO; j++) begin
         nxt_data[j] = '0;
         nxt_keep[j] = 1'b0;
         if (IW'(j) < idx) begin
            nxt_data[j] = acc[j];
            nxt_keep[j] = 1'b1;
         end else if (IW'(j) == idx) begin
            nxt_data[j] = s_data_i;
            nxt_keep[j] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < T_DATA_RATIO; j++) begin
         if (wr && !close && (IW'(j) == idx)) begin
            acc[j] <= s_data_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx       <= '0;
         m_keep_o  <= '0;
         m_last_o  <= 1'b0;
         m_valid_o <= 1'b0;
         for (int j = 0; j < T_DATA_RATIO; j++) begin
            m_data_o[j] <= '0;
         end
      end else begin
         if (wr) begin
            idx <= close ? '0 : idx + IW'(1);
         end
         // A closing beat wins over a drain so the pipe never bubbles.
         if (close) begin
            m_keep_o  <= nxt_keep;
            m_last_o  <= s_last_i;
            m_valid_o <= 1'b1;
            for (int j = 0; j < T_DATA_RATIO; j++) begin
               m_data_o[j] <= nxt_data[j];
            end
         end else if (rd) begin
            m_keep_o  <= '0;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b0;
            for (int j = 0; j < T_DATA_RATIO; j++) begin
               m_data_o[j] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_upsize_pipe.sv
// Directed bench for stream_upsize_pipe at ratios 1, 2, 3 and 4.
module tb_stream_upsize_pipe;

   logic clk = 1'b0;
   logic rst_n;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   logic [3:0] d1, md1 [1];
   logic       l1, v1, r1, ml1, mv1, mr1;
   logic [0:0] mk1;
   logic [3:0] d2, md2 [2];
   logic       l2, v2, r2, ml2, mv2, mr2;
   logic [1:0] mk2;
   logic [3:0] d3, md3 [3];
   logic       l3, v3, r3, ml3, mv3, mr3;
   logic [2:0] mk3;
   logic [3:0] d4, md4 [4];
   logic       l4, v4, r4, ml4, mv4, mr4;
   logic [3:0] mk4;

   stream_upsize_pipe #(.T_DATA_WIDTH(4), .T_DATA_RATIO(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(d1), .s_last_i(l1), .s_valid_i(v1), .s_ready_o(r1),
      .m_data_o(md1), .m_keep_o(mk1), .m_last_o(ml1),
      .m_valid_o(mv1), .m_ready_i(mr1));
   stream_upsize_pipe #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) u2 (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(d2), .s_last_i(l2), .s_valid_i(v2), .s_ready_o(r2),
      .m_data_o(md2), .m_keep_o(mk2), .m_last_o(ml2),
      .m_valid_o(mv2), .m_ready_i(mr2));
   stream_upsize_pipe #(.T_DATA_WIDTH(4), .T_DATA_RATIO(3)) u3 (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(d3), .s_last_i(l3), .s_valid_i(v3), .s_ready_o(r3),
      .m_data_o(md3), .m_keep_o(mk3), .m_last_o(ml3),
      .m_valid_o(mv3), .m_ready_i(mr3));
   stream_upsize_pipe #(.T_DATA_WIDTH(4), .T_DATA_RATIO(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(d4), .s_last_i(l4), .s_valid_i(v4), .s_ready_o(r4),
      .m_data_o(md4), .m_keep_o(mk4), .m_last_o(ml4),
      .m_valid_o(mv4), .m_ready_i(mr4));

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [15:0] w4;
      rst_n = 1'b0;
      d1 = '0; l1 = 0; v1 = 0; mr1 = 1;
      d2 = '0; l2 = 0; v2 = 0; mr2 = 1;
      d3 = '0; l3 = 0; v3 = 0; mr3 = 1;
      d4 = '0; l4 = 0; v4 = 0; mr4 = 1;
      @(negedge clk);
      step();
      vecs++;
      if ({r1, r2, r3, r4} !== 4'b0000) begin
         errs++;
         $display("FAIL rst_ready got %b want 0000", {r1, r2, r3, r4});
      end
      vecs++;
      if ({mv1, mv2, mv3, mv4} !== 4'b0000) begin
         errs++;
         $display("FAIL rst_valid got %b want 0000", {mv1, mv2, mv3, mv4});
      end
      w4 = {md4[3], md4[2], md4[1], md4[0]};
      vecs++;
      if ({w4, mk4, ml4} !== 21'h0) begin
         errs++;
         $display("FAIL rst_out4 got %h want 0", {w4, mk4, ml4});
      end
      rst_n = 1'b1;
      #1;
      vecs++;
      if ({r1, r2, r3, r4} !== 4'b1111) begin
         errs++;
         $display("FAIL rel_ready got %b want 1111", {r1, r2, r3, r4});
      end
   endtask

   task automatic test_full_word();
      mr2 = 1; v2 = 1; l2 = 0; d2 = 4'hA;
      step();
      vecs++;
      if (mv2 !== 1'b0) begin
         errs++;
         $display("FAIL fw_early got %b want 0", mv2);
      end
      d2 = 4'hB;
      step();
      v2 = 0;
      vecs++;
      if ({mv2, md2[1], md2[0], mk2, ml2} !== {1'b1, 8'hBA, 2'b11, 1'b0}) begin
         errs++;
         $display("FAIL fw_word got %b %h%h %b %b want 1 ba 11 0",
                  mv2, md2[1], md2[0], mk2, ml2);
      end
      step();
      vecs++;
      if ({mv2, md2[1], md2[0], mk2} !== 11'h0) begin
         errs++;
         $display("FAIL fw_drain got %b %h%h %b want 0 00 00",
                  mv2, md2[1], md2[0], mk2);
      end
   endtask

   task automatic test_partial();
      mr4 = 1; v4 = 1; l4 = 0; d4 = 4'h1;
      step();
      l4 = 1; d4 = 4'h2;
      step();
      v4 = 0; l4 = 0;
      vecs++;
      if ({mv4, md4[3], md4[2], md4[1], md4[0], mk4, ml4} !==
          {1'b1, 16'h0021, 4'b0011, 1'b1}) begin
         errs++;
         $display("FAIL part_word got %b %h%h%h%h %b %b want 1 0021 0011 1",
                  mv4, md4[3], md4[2], md4[1], md4[0], mk4, ml4);
      end
      step();
      v4 = 1; l4 = 1; d4 = 4'h3;
      step();
      v4 = 0; l4 = 0;
      vecs++;
      if ({mv4, md4[3], md4[2], md4[1], md4[0], mk4, ml4} !==
          {1'b1, 16'h0003, 4'b0001, 1'b1}) begin
         errs++;
         $display("FAIL part_lane0 got %b %h%h%h%h %b %b want 1 0003 0001 1",
                  mv4, md4[3], md4[2], md4[1], md4[0], mk4, ml4);
      end
      step();
   endtask

   task automatic test_backpressure();
      mr2 = 0; v2 = 1; l2 = 0; d2 = 4'h1;
      step();
      d2 = 4'h2;
      step();
      d2 = 4'h3;
      for (int c = 0; c < 5; c++) begin
         #1;
         vecs++;
         if ({r2, mv2, md2[1], md2[0], mk2, ml2} !==
             {1'b0, 1'b1, 8'h21, 2'b11, 1'b0}) begin
            errs++;
            $display("FAIL bp_hold%0d got %b %b %h%h %b %b want 0 1 21 11 0",
                     c, r2, mv2, md2[1], md2[0], mk2, ml2);
         end
         step();
      end
      mr2 = 1;
      #1;
      vecs++;
      if (r2 !== 1'b1) begin
         errs++;
         $display("FAIL bp_ready got %b want 1", r2);
      end
      step();
      vecs++;
      if (mv2 !== 1'b0) begin
         errs++;
         $display("FAIL bp_drain got %b want 0", mv2);
      end
      d2 = 4'h4;
      step();
      v2 = 0;
      vecs++;
      if ({mv2, md2[1], md2[0], mk2} !== {1'b1, 8'h43, 2'b11}) begin
         errs++;
         $display("FAIL bp_resume got %b %h%h %b want 1 43 11",
                  mv2, md2[1], md2[0], mk2);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [11:0] want;
      int beats;
      int words;
      mr3 = 1; l3 = 0;
      for (int i = 0; i < 30; i++) begin
         v3 = 1; d3 = 4'(i);
         #1;
         vecs++;
         if (r3 !== 1'b1) begin
            errs++;
            $display("FAIL b2b_ready%0d got %b want 1", i, r3);
         end
         step();
         if (i % 3 == 2) begin
            want = {4'(i), 4'(i - 1), 4'(i - 2)};
            vecs++;
            if ({mv3, md3[2], md3[1], md3[0], mk3} !== {1'b1, want, 3'b111}) begin
               errs++;
               $display("FAIL b2b_word%0d got %b %h%h%h %b want 1 %h 111",
                        i / 3, mv3, md3[2], md3[1], md3[0], mk3, want);
            end
         end else begin
            vecs++;
            if (mv3 !== 1'b0) begin
               errs++;
               $display("FAIL b2b_gap%0d got %b want 0", i, mv3);
            end
         end
      end
      v3 = 0;
      step();
      beats = 0;
      words = 0;
      for (int c = 0; c < 500 && words < 10; c++) begin
         mr3 = 1'($urandom_range(0, 1));
         v3 = (beats < 30);
         d3 = 4'(beats);
         #1;
         if (mv3 && mr3) begin
            want = {4'(3 * words + 2), 4'(3 * words + 1), 4'(3 * words)};
            vecs++;
            if ({md3[2], md3[1], md3[0], mk3} !== {want, 3'b111}) begin
               errs++;
               $display("FAIL rnd_word%0d got %h%h%h %b want %h 111",
                        words, md3[2], md3[1], md3[0], mk3, want);
            end
            words++;
         end
         if (v3 && r3) beats++;
         step();
      end
      v3 = 0; mr3 = 1;
      vecs++;
      if (words != 10) begin
         errs++;
         $display("FAIL rnd_count got %0d want 10", words);
      end
      step();
   endtask

   task automatic test_ratio1();
      mr1 = 1; v1 = 1; l1 = 1; d1 = 4'h5;
      step();
      vecs++;
      if ({mv1, md1[0], mk1, ml1} !== {1'b1, 4'h5, 1'b1, 1'b1}) begin
         errs++;
         $display("FAIL r1_w0 got %b %h %b %b want 1 5 1 1",
                  mv1, md1[0], mk1, ml1);
      end
      l1 = 0; d1 = 4'h6;
      step();
      v1 = 0;
      vecs++;
      if ({mv1, md1[0], mk1, ml1} !== {1'b1, 4'h6, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL r1_w1 got %b %h %b %b want 1 6 1 0",
                  mv1, md1[0], mk1, ml1);
      end
      step();
      vecs++;
      if (mv1 !== 1'b0) begin
         errs++;
         $display("FAIL r1_drain got %b want 0", mv1);
      end
   endtask

   task automatic test_reset_mid_word();
      int seen;
      mr4 = 1; v4 = 1; l4 = 0; d4 = 4'hE;
      step();
      d4 = 4'hF;
      step();
      v4 = 0; rst_n = 0;
      step();
      rst_n = 1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         v4 = 1; d4 = 4'(7 + i);
         step();
         if (mv4) seen++;
      end
      v4 = 0;
      vecs++;
      if ({mv4, md4[3], md4[2], md4[1], md4[0], mk4, ml4} !==
          {1'b1, 16'hA987, 4'b1111, 1'b0}) begin
         errs++;
         $display("FAIL rmw_word got %b %h%h%h%h %b %b want 1 a987 1111 0",
                  mv4, md4[3], md4[2], md4[1], md4[0], mk4, ml4);
      end
      step();
      if (mv4) seen++;
      vecs++;
      if (seen != 1) begin
         errs++;
         $display("FAIL rmw_count got %0d want 1", seen);
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial();
      test_backpressure();
      test_back_to_back();
      test_ratio1();
      test_reset_mid_word();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
